// File: rtl/frac_div_ctrl.sv
// frac_div_ctrl: fractional-N divider control; period = n_int + sigma-delta offset,
// clamped to a minimum of 2, with a ~50% duty divided clock and a sticky clamp flag.
module frac_div_ctrl #(
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [NW-1:0] n_int,
    input  logic [3:0]    sdm_in,
    output logic          sdm_strobe,
    output logic          div_pulse,
    output logic          div_out,
    output logic          clamp_flag
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                state_q;
    logic [NW:0]           cnt_q, d_cur_q, d_eff;
    logic signed [NW+1:0]  d_raw;
    logic                  clamp;
    // two guard bits keep n_int + sdm_in free of wrap at both ends of the range
    always_comb begin
        d_raw = $signed({2'b00, n_int}) + $signed({{(NW-2){sdm_in[3]}}, sdm_in});
        clamp = d_raw[NW+1] || (d_raw[NW:1] == '0);
        d_eff = clamp ? (NW+1)'(2) : d_raw[NW:0];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_cur_q    <= (NW+1)'(2);
            sdm_strobe <= 1'b0;
            div_pulse  <= 1'b0;
            div_out    <= 1'b0;
            clamp_flag <= 1'b0;
        end else if (!en) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sdm_strobe <= 1'b0;
            div_pulse  <= 1'b0;
            div_out    <= 1'b0;
            if (state_q == IDLE) clamp_flag <= 1'b0;
        end else if (state_q == IDLE || cnt_q == '0) begin
            div_pulse  <= state_q == RUN;
            state_q    <= RUN;
            d_cur_q    <= d_eff;
            cnt_q      <= d_eff - 1'b1;
            sdm_strobe <= 1'b1;
            div_out    <= 1'b1;
            clamp_flag <= clamp_flag | clamp;
        end else begin
            cnt_q      <= cnt_q - 1'b1;
            sdm_strobe <= 1'b0;
            div_pulse  <= 1'b0;
            if (cnt_q == (d_cur_q >> 1)) div_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frac_div_ctrl.sv
// tb_frac_div_ctrl: scoreboard bench; expected periods are queued at each strobe from
// the consumed n_int/sdm_in, and a monitor measures spacing and high time per period.
module tb_frac_div_ctrl;
    localparam int NW = 8;
    logic          clk = 1'b0, rstn = 1'b1, en = 1'b0;
    logic [NW-1:0] n_int = '0;
    logic [3:0]    sdm_in = '0;
    logic          sdm_strobe, div_pulse, div_out, clamp_flag;
    int vectors = 0, miscompares = 0;
    int n_v = 0, s_v = 0;
    bit clamp_m = 1'b0;
    typedef struct {int d; int hi;} exp_t;
    exp_t exp_q[$];
    bit run_active = 1'b0;
    int cyc = 0, hi = 0, stray = 0;

    always #5 clk = ~clk;

    frac_div_ctrl #(.NW(NW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .n_int(n_int), .sdm_in(sdm_in),
        .sdm_strobe(sdm_strobe), .div_pulse(div_pulse), .div_out(div_out),
        .clamp_flag(clamp_flag)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic set_in(input int n, input int s);
        n_v = n;
        s_v = s;
        n_int = n[NW-1:0];
        sdm_in = s[3:0];
    endtask

    // reference: period = max(2, n + s), high time = ceil(period / 2)
    task automatic on_strobe(input int mode);
        exp_t e;
        int d;
        d = n_v + s_v;
        if (d < 2) begin
            d = 2;
            clamp_m = 1'b1;
        end
        e.d = d;
        e.hi = (d + 1) / 2;
        exp_q.push_back(e);
        check("clamp_flag", clamp_flag, clamp_m);
        if (mode == 1) set_in(n_v, s_v == 1 ? -1 : 1);
        else if (mode == 2)
            set_in($urandom_range(0, 9) == 0 ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 30)),
                   int'($urandom_range(0, 7)) - 3);
    endtask

    task automatic run_periods(input int k, input int mode);
        int got = 0, waitc = 0;
        while (got < k) begin
            @(posedge clk);
            #2;
            if (sdm_strobe) begin
                got++;
                waitc = 0;
                on_strobe(mode);
            end else if (++waitc > 400) begin
                vectors++;
                miscompares++;
                $display("FAIL strobe_timeout: no sdm_strobe within 400 cycles at %0t", $time);
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rstn || !en) run_active = 1'b0;
        else if (sdm_strobe) begin
            check("pulse_at_strobe", div_pulse, run_active);
            if (run_active) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty: strobe with no expected period at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("period", cyc, e.d);
                    check("high_time", hi, e.hi);
                    check("stray_pulse", stray, 0);
                end
            end
            run_active = 1'b1;
            cyc = 1;
            hi = div_out ? 1 : 0;
            stray = 0;
        end else if (run_active) begin
            cyc++;
            hi += div_out ? 1 : 0;
            stray += div_pulse ? 1 : 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rstn = 1'b0;
        #1;
        check("rst_strobe", sdm_strobe, 0);
        check("rst_pulse", div_pulse, 0);
        check("rst_div_out", div_out, 0);
        check("rst_clamp", clamp_flag, 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        set_in(10, 0);
        @(posedge clk);
        #2 en = 1'b1;
        run_periods(5, 0);
        run_periods(6, 1);
        set_in(1, -3);
        run_periods(5, 0);
        en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        clamp_m = 1'b0;
        check("clamp_cleared", clamp_flag, clamp_m);
        check("idle_div_out", div_out, 0);
        set_in(255, 4);
        en = 1'b1;
        run_periods(3, 0);
        set_in(10, 0);
        run_periods(2, 0);
        set_in(20, 0);
        run_periods(3, 0);
        run_periods(60, 2);
        set_in(6, 0);
        run_periods(2, 0);
        repeat (5) @(posedge clk);
        #2 en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        check("drop_strobe", sdm_strobe, 0);
        check("drop_pulse", div_pulse, 0);
        check("drop_div_out", div_out, 0);
        set_in(12, 0);
        en = 1'b1;
        run_periods(2, 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_div_out", div_out, 0);
        check("arst_strobe", sdm_strobe, 0);
        check("arst_pulse", div_pulse, 0);
        exp_q.delete();
        clamp_m = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #2;
        check("strobe_after_rst", sdm_strobe, 1);
        on_strobe(0);
        run_periods(3, 0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frac_div_ctrl.md
FRAC_DIV_CTRL -- requirements
Module: frac_div_ctrl

Interface
REQ-001 Parameter NW, default 8, SHALL set the width of the integer divide word n_int (legal range 3..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 en  input  1  SHALL enable division; low forces IDLE.
REQ-005 n_int  input  NW  SHALL be the unsigned integer divide ratio.
REQ-006 sdm_in  input  4  SHALL be the two's-complement fractional offset from the sigma-delta modulator, range -3..+4.
REQ-007 sdm_strobe  output  1  SHALL pulse for one cycle each time sdm_in is consumed; it is the modulator's clock enable.
REQ-008 div_pulse  output  1  SHALL pulse for one cycle per divided period.
REQ-009 div_out  output  1  SHALL be the divided clock, duty about 50%.
REQ-010 clamp_flag  output  1  SHALL be sticky, indicating that at least one ratio was clamped.

Function
REQ-011 The block SHALL have two states: IDLE and RUN.
REQ-012 Effective ratio D SHALL be computed as n_int (zero-extended) plus sdm_in (sign-extended) in NW+2-bit signed arithmetic.
REQ-013 If D < 2, D SHALL be replaced by 2 and clamp_flag SHALL be set; D SHALL be held in an NW+1-bit register d_cur.
REQ-014 Max D = 2^NW+3 SHALL be representable without wrap.
REQ-015 IDLE->RUN SHALL occur on an edge with en=1; at that edge: load D, counter <= D-1, sdm_strobe <= 1, div_out <= 1, div_pulse <= 0.
REQ-016 In RUN with counter != 0, counter SHALL decrement by 1 per cycle.
REQ-017 In RUN with counter == 0 (reload edge): recompute D from current n_int/sdm_in, counter <= D-1, d_cur <= D, div_pulse <= 1, sdm_strobe <= 1, div_out <= 1.
REQ-018 div_pulse and sdm_strobe SHALL be 0 on every non-reload edge.
REQ-019 In RUN, an edge with counter == (d_cur >> 1) and counter != 0 SHALL set div_out <= 0, giving ceil(D/2) cycles high and floor(D/2) cycles low.
REQ-020 Spacing between consecutive div_pulse SHALL equal the D loaded at the earlier reload; the first div_pulse SHALL occur D cycles after the first sdm_strobe.
REQ-021 Changes to n_int/sdm_in mid-period SHALL have no effect until the next reload edge.
REQ-022 en=0 sampled in RUN SHALL force IDLE at that edge: counter <= 0, div_out <= 0, div_pulse <= 0, sdm_strobe <= 0, overriding a coincident reload.
REQ-023 clamp_flag SHALL clear only on reset or on an edge in IDLE with en=0.
REQ-024 Setting clamp_flag SHALL take priority over clearing it when both occur on the same edge.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 rstn=0 SHALL immediately force state=IDLE, counter=0, d_cur=2, and sdm_strobe=0, div_pulse=0, div_out=0, clamp_flag=0, regardless of clk.
REQ-027 Release of rstn SHALL take effect at the next rising clk edge; reset asserted mid-period SHALL abort the period with no trailing pulse.

Verification
REQ-028 n_int=10, sdm_in=0, en=1: div_pulse every 10 cycles; div_out 5 high/5 low; sdm_strobe coincident with div_pulse.
REQ-029 n_int=10, sdm_in alternating +1/-1 (updated after each strobe): pulse spacings 11,9,11,9; div_out high 6/low 5, then high 5/low 4.
REQ-030 n_int=1, sdm_in=-3: D clamps to 2; div_pulse every 2 cycles; clamp_flag=1 and held; en=0 for one IDLE cycle clears it.
REQ-031 NW=8, n_int=255, sdm_in=+4: spacing 259 cycles; no wrap; clamp_flag=0.
REQ-032 n_int changed 10->20 mid-period: current period stays 10, next period is 20.
REQ-033 en dropped at the counter==0 edge: no div_pulse/sdm_strobe, outputs 0. rstn pulsed asynchronously mid-period: outputs 0 immediately; after release with en=1, first strobe on the next edge.
